// File: rtl/cache_config.sv
// Shared cache geometry and refill FSM state encoding.
package cache_config;

  localparam int unsigned CACHE_ADDR_SIZE  = 32;
  localparam int unsigned CACHE_DATA_SIZE  = 32;
  localparam int unsigned CACHE_BLOCK_SIZE = 16;

  localparam int unsigned WORDS_PER_BLOCK = (CACHE_BLOCK_SIZE * 8) / CACHE_DATA_SIZE;
  localparam int unsigned LINE_BITS       = CACHE_BLOCK_SIZE * 8;
  localparam int unsigned OFFSET_BITS     = $clog2(CACHE_BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line refill controller: optional write-back of a dirty victim, then a
// word-by-word read of the missing line, then a one-cycle fill pulse.
module cache_refill_ctrl
  import cache_config::*;
#(
  parameter int unsigned ADDR_SIZE  = CACHE_ADDR_SIZE,
  parameter int unsigned DATA_SIZE  = CACHE_DATA_SIZE,
  parameter int unsigned BLOCK_SIZE = CACHE_BLOCK_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [ADDR_SIZE-1:0]    miss_addr,
  input  logic                    wb_dirty,
  input  logic [ADDR_SIZE-1:0]    wb_addr,
  input  logic [BLOCK_SIZE*8-1:0] wb_line,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_SIZE-1:0]    mem_addr,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_SIZE-1:0]    mem_rdata,
  output logic                    fill_valid,
  output logic [ADDR_SIZE-1:0]    fill_addr,
  output logic [BLOCK_SIZE*8-1:0] fill_line
);

  localparam int unsigned NWORDS = (BLOCK_SIZE * 8) / DATA_SIZE;
  localparam int unsigned LBITS  = BLOCK_SIZE * 8;
  localparam int unsigned OFFB   = $clog2(BLOCK_SIZE);
  localparam int unsigned WORDB  = $clog2(DATA_SIZE / 8);
  localparam int unsigned BEATB  = $clog2(NWORDS);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK  = ADDR_SIZE'((64'd1 << OFFB) - 64'd1);
  localparam logic [BEATB-1:0]     LAST_BEAT = BEATB'(NWORDS - 1);

  refill_state_e        state_q, state_d;
  logic [BEATB-1:0]     beat_q, beat_d;
  logic [ADDR_SIZE-1:0] miss_base_q, miss_base_d;
  logic [ADDR_SIZE-1:0] wb_base_q, wb_base_d;
  logic [LBITS-1:0]     wbuf_q, wbuf_d;
  logic [LBITS-1:0]     line_q, line_d;
  logic [ADDR_SIZE-1:0] beat_off_s;

  // Bases have their offset bits cleared, so OR-ing in the beat offset
  // can never carry into the tag.
  assign beat_off_s = ADDR_SIZE'(beat_q) << WORDB;

  // Next-state, beat counter and line-buffer update.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    miss_base_d = miss_base_q;
    wb_base_d   = wb_base_q;
    wbuf_d      = wbuf_q;
    line_d      = line_q;
    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          miss_base_d = miss_addr & ~OFF_MASK;
          wb_base_d   = wb_addr & ~OFF_MASK;
          wbuf_d      = wb_line;
          line_d      = '0;
          beat_d      = '0;
          state_d     = wb_dirty ? WB : RD;
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        if (mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = RD;
          end else begin
            beat_d = beat_q + BEATB'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      RD: begin
        if (mem_ack) begin
          line_d[int'(beat_q)*DATA_SIZE +: DATA_SIZE] = mem_rdata;
          beat_d = beat_q + BEATB'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            state_d = RD;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      miss_base_q <= '0;
      wb_base_q   <= '0;
      wbuf_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      miss_base_q <= miss_base_d;
      wb_base_q   <= wb_base_d;
      wbuf_q      <= wbuf_d;
      line_q      <= line_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    miss_ready = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_line  = '0;
    case (state_q)
      IDLE: miss_ready = 1'b1;
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_base_q | beat_off_s;
        mem_wdata = wbuf_q[int'(beat_q)*DATA_SIZE +: DATA_SIZE];
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = miss_base_q | beat_off_s;
      end
      DONE: begin
        fill_valid = 1'b1;
        fill_addr  = miss_base_q;
        fill_line  = line_q;
      end
      default: miss_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a beat/fill scoreboard.
module tb_cache_refill_ctrl;
  import cache_config::*;

  logic         clk;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic         wb_dirty;
  logic [31:0]  wb_addr;
  logic [127:0] wb_line;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_line;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t        exp_beats[$];
  logic [31:0]  exp_faddr[$];
  logic [127:0] exp_fline[$];
  int checks   = 0;
  int failures = 0;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .wb_dirty(wb_dirty), .wb_addr(wb_addr), .wb_line(wb_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One miss transaction; stall_at/abort_at count completed beats (-1 = off).
  task automatic txn(input string nm, input logic [31:0] maddr, input logic dirty,
                     input logic [31:0] waddr, input logic [127:0] wline,
                     input logic [127:0] rline, input int stall_at, input int stall_len,
                     input int exp_lat, input int abort_at, input bit noise);
    logic [31:0] mb;
    logic [31:0] wbb;
    int cyc;
    int done_beats;
    int stall_cnt;
    bit filled;
    bit aborted;
    beat_t b;
    logic [1:0] idx;
    mb  = maddr & 32'hFFFF_FFF0;
    wbb = waddr & 32'hFFFF_FFF0;
    if (dirty)
      for (int i = 0; i < 4; i++) exp_beats.push_back({1'b1, wbb + 32'(4*i), wline[32*i +: 32]});
    for (int i = 0; i < 4; i++) exp_beats.push_back({1'b0, mb + 32'(4*i), 32'h0});
    exp_faddr.push_back(mb);
    exp_fline.push_back(rline);

    miss_valid = 1'b1; miss_addr = maddr; wb_dirty = dirty; wb_addr = waddr; wb_line = wline;
    mem_ack = 1'b0;
    @(negedge clk);
    chk({nm, ":ready_idle"}, {127'd0, miss_ready}, 128'd1);
    next_cycle();
    miss_valid = noise;
    miss_addr  = noise ? 32'h0000_9990 : maddr;
    wb_dirty   = noise;
    cyc = 1; done_beats = 0; stall_cnt = 0; filled = 1'b0; aborted = 1'b0;

    for (int k = 0; k < 40 && !filled && !aborted; k++) begin
      if (abort_at >= 0 && done_beats == abort_at) begin
        rst = 1'b1; miss_valid = 1'b0; mem_ack = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk({nm, ":rst_req"}, {127'd0, mem_req}, 128'd0);
        chk({nm, ":rst_fill"}, {127'd0, fill_valid}, 128'd0);
        chk({nm, ":rst_ready"}, {127'd0, miss_ready}, 128'd1);
        exp_beats.delete(); exp_faddr.delete(); exp_fline.delete();
        for (int j = 0; j < 6; j++) begin
          next_cycle();
          @(negedge clk);
          chk({nm, ":post_rst_req"}, {127'd0, mem_req}, 128'd0);
          chk({nm, ":post_rst_fill"}, {127'd0, fill_valid}, 128'd0);
        end
        next_cycle();
        aborted = 1'b1;
      end else begin
        if (done_beats == stall_at && stall_cnt < stall_len) begin
          mem_ack = 1'b0;
          stall_cnt++;
        end else begin
          mem_ack = 1'b1;
        end
        mem_rdata = 32'hDEAD_BEEF;
        if (exp_beats.size() > 0) begin
          b = exp_beats[0];
          idx = b.addr[3:2];
          if (!b.we) mem_rdata = rline[32*idx +: 32];
        end
        @(negedge clk);
        chk({nm, ":busy_ready"}, {127'd0, miss_ready}, 128'd0);
        chk({nm, ":req"}, {127'd0, mem_req}, {127'd0, exp_beats.size() > 0});
        if (fill_valid) begin
          chk({nm, ":latency"}, 128'(cyc), 128'(exp_lat));
          if (exp_faddr.size() > 0) begin
            chk({nm, ":fill_addr"}, {96'd0, fill_addr}, {96'd0, exp_faddr.pop_front()});
            chk({nm, ":fill_line"}, fill_line, exp_fline.pop_front());
          end
          filled = 1'b1;
        end
        if (mem_req && exp_beats.size() > 0) begin
          chk({nm, ":beat"}, {63'd0, mem_we, mem_addr, mem_wdata}, {63'd0, exp_beats[0]});
          if (mem_ack) begin
            void'(exp_beats.pop_front());
            done_beats++;
          end
        end else begin
          chk({nm, ":idle_bus"}, {95'd0, mem_we, mem_wdata}, 128'd0);
        end
        next_cycle();
        cyc++;
      end
    end
    miss_valid = 1'b0;
    if (abort_at < 0) begin
      chk({nm, ":completed"}, {127'd0, filled}, 128'd1);
      mem_ack = 1'b0;
      @(negedge clk);
      chk({nm, ":fill_pulse"}, {127'd0, fill_valid}, 128'd0);
      chk({nm, ":ready_again"}, {127'd0, miss_ready}, 128'd1);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_addr = 32'h0; wb_dirty = 1'b0; wb_addr = 32'h0;
    wb_line = 128'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_outs", {mem_req, mem_we, fill_valid, mem_addr, mem_wdata, fill_addr},
        {3'b000, 32'h0, 32'h0, 32'h0});
    chk("reset_line", fill_line, 128'd0);
    chk("reset_ready", {127'd0, miss_ready}, 128'd1);
    next_cycle();
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      chk("stray_ack", {126'd0, mem_req, fill_valid}, 128'd0);
    end
    next_cycle();

    txn("clean", 32'h0000_1234, 1'b0, 32'h0, 128'h0,
        {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0, 5, -1, 1'b0);
    txn("dirty", 32'h0000_3000, 1'b1, 32'h0000_2040,
        {32'hD3, 32'hD2, 32'hD1, 32'hD0},
        {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1, 0, 9, -1, 1'b0);
    txn("stall", 32'h0000_5008, 1'b1, 32'h0000_6014,
        {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000},
        {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}, 1, 3, 12, -1, 1'b0);
    txn("wrap", 32'hFFFF_FFF8, 1'b0, 32'h0, 128'h0,
        {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, -1, 0, 5, -1, 1'b0);
    txn("abort", 32'h0000_4000, 1'b0, 32'h0, 128'h0,
        {32'hE3, 32'hE2, 32'hE1, 32'hE0}, -1, 0, 5, 3, 1'b1);
    txn("after_rst", 32'h0000_0A10, 1'b0, 32'h0, 128'h0,
        {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000}, 2, 1, 6, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
